// File: rtl/mult_acc_drain.sv
// Product accumulator that streams its contents out LSB-byte first on request.
// Define MULT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module mult_acc_drain #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  input  logic              acc_clear,
  input  logic              drain_req,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned NumBytes = ACC_W / 8;
  localparam int unsigned CntW     = $clog2(NumBytes + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

  if ((ACC_W % 8) != 0 || ACC_W < PROD_W) begin : g_bad_param
    $error("mult_acc_drain: ACC_W must be a multiple of 8 and >= PROD_W");
  end

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    sum;
  logic              accept;

  assign prod_ready = (state_q == StIdle) && !drain_req && !rst;
  assign accept     = prod_valid && prod_ready;
  assign out_byte   = shift_q[7:0];
  assign out_valid  = (state_q == StDrain);
  assign busy       = (state_q == StDrain);
  assign ovf        = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    // Clear takes effect before a same-cycle add.
    acc_base = ((state_q == StIdle) && acc_clear) ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};

    unique case (state_q)
      StIdle: begin
        if (acc_clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (accept) begin
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef MULT_ACC_SAT_EN
            acc_d = '1;
`else
            acc_d = sum[ACC_W-1:0];
`endif
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
        end
        if (drain_req) begin
          shift_d = acc_q;
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ack) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_acc_drain.sv
// Directed self-checking bench for mult_acc_drain (default 16/24-bit configuration).
module tb_mult_acc_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [15:0] prod_data;
  logic        prod_ready;
  logic        acc_clear;
  logic        drain_req;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ack;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_acc_drain #(.PROD_W(16), .ACC_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .acc_clear  (acc_clear),
    .drain_req  (drain_req),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .busy       (busy),
    .ovf        (ovf)
  );

  typedef struct {
    logic [15:0] prod;
    int          reps;
    bit          clr;
    logic [23:0] exp_acc;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p);
    prod_valid = 1'b1;
    prod_data  = p;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic clear_acc();
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
  endtask

  task automatic drain(output logic [23:0] got);
    got = '0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int w = 0;
      while (!out_valid && w < 4) begin
        tick();
        w++;
      end
      check("drain_out_valid", {31'b0, out_valid}, 32'd1);
      got[8*i +: 8] = out_byte;
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
    end
    check("drain_done_valid", {31'b0, out_valid}, 32'd0);
    check("drain_done_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] got;

    vecs[0] = '{prod: 16'h1234, reps: 1, clr: 1'b1, exp_acc: 24'h001234, exp_ovf: 1'b0};
    vecs[1] = '{prod: 16'h0001, reps: 1, clr: 1'b0, exp_acc: 24'h001235, exp_ovf: 1'b0};
    vecs[2] = '{prod: 16'hFFFF, reps: 1, clr: 1'b0, exp_acc: 24'h011234, exp_ovf: 1'b0};
`ifdef MULT_ACC_SAT_EN
    vecs[3] = '{prod: 16'hFFFF, reps: 257, clr: 1'b1, exp_acc: 24'hFFFFFF, exp_ovf: 1'b1};
    vecs[4] = '{prod: 16'h0101, reps: 1, clr: 1'b0, exp_acc: 24'hFFFFFF, exp_ovf: 1'b1};
`else
    vecs[3] = '{prod: 16'hFFFF, reps: 257, clr: 1'b1, exp_acc: 24'h00FEFF, exp_ovf: 1'b1};
    vecs[4] = '{prod: 16'h0101, reps: 1, clr: 1'b0, exp_acc: 24'h010000, exp_ovf: 1'b1};
`endif
    vecs[5] = '{prod: 16'h0002, reps: 3, clr: 1'b1, exp_acc: 24'h000006, exp_ovf: 1'b0};

    // Reset held for two cycles with a product presented
    rst = 1'b1; prod_valid = 1'b1; prod_data = 16'h1234;
    acc_clear = 1'b0; drain_req = 1'b0; out_ack = 1'b0;
    #1;
    check("rst_prod_ready", {31'b0, prod_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_prod_ready_hold", {31'b0, prod_ready}, 32'd0);
      check("rst_out_byte", {24'b0, out_byte}, 32'd0);
    end
    prod_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_prod_ready", {31'b0, prod_ready}, 32'd1);
    check("post_rst_ovf", {31'b0, ovf}, 32'd0);
    drain(got);
    check("post_rst_drain", {8'b0, got}, 32'h000000);

    // Table-driven accumulation / overflow vectors
    foreach (vecs[k]) begin
      if (vecs[k].clr) clear_acc();
      for (int r = 0; r < vecs[k].reps; r++) push(vecs[k].prod);
      check($sformatf("vec%0d_ovf", k), {31'b0, ovf}, {31'b0, vecs[k].exp_ovf});
      drain(got);
      check($sformatf("vec%0d_acc", k), {8'b0, got}, {8'b0, vecs[k].exp_acc});
      check($sformatf("vec%0d_ovf_after_drain", k), {31'b0, ovf}, {31'b0, vecs[k].exp_ovf});
    end

    // Backpressure: stalled byte stays put, products and clear ignored in DRAIN
    clear_acc();
    push(16'hA1B2);
    out_ack = 1'b1;
    tick();
    tick();
    out_ack = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    prod_valid = 1'b1; prod_data = 16'h0100; acc_clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_prod_ready", {31'b0, prod_ready}, 32'd0);
      tick();
      acc_clear = 1'b0;
      check("bp_out_byte", {24'b0, out_byte}, 32'hB2);
      check("bp_busy", {31'b0, busy}, 32'd1);
    end
    prod_valid = 1'b0;
    got = '0;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      got[8*i +: 8] = out_byte;
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
    end
    check("bp_bytes", {8'b0, got}, 32'h00A1B2);
    check("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    drain(got);
    check("bp_acc_untouched", {8'b0, got}, 32'h00A1B2);

    // Simultaneous clear and add after an overflow
    clear_acc();
    for (int i = 0; i < 256; i++) push(16'hFFFF);
    push(16'h0105);
    check("ca_ovf_set", {31'b0, ovf}, 32'd1);
    drain(got);
`ifdef MULT_ACC_SAT_EN
    check("ca_pre_acc", {8'b0, got}, 32'hFFFFFF);
`else
    check("ca_pre_acc", {8'b0, got}, 32'h000005);
`endif
    acc_clear = 1'b1; prod_valid = 1'b1; prod_data = 16'h0010;
    tick();
    acc_clear = 1'b0; prod_valid = 1'b0;
    check("ca_ovf_cleared", {31'b0, ovf}, 32'd0);
    drain(got);
    check("ca_acc", {8'b0, got}, 32'h000010);

    // Reset mid-drain
    push(16'h0203);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("md_byte0", {24'b0, out_byte}, 32'h13);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("md_byte1", {24'b0, out_byte}, 32'h02);
    rst = 1'b1;
    #1;
    check("md_rst_prod_ready", {31'b0, prod_ready}, 32'd0);
    tick();
    check("md_out_valid", {31'b0, out_valid}, 32'd0);
    check("md_busy", {31'b0, busy}, 32'd0);
    check("md_out_byte", {24'b0, out_byte}, 32'd0);
    rst = 1'b0;
    tick();
    check("md_idle_valid", {31'b0, out_valid}, 32'd0);
    drain(got);
    check("md_acc_zero", {8'b0, got}, 32'h000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
